rom_sel_ctl: RTL and testbench
==============================

ROM_SEL_CTL -- requirements
Module: rom_sel_ctl

Interface
REQ-001 SHALL have parameter N_ROM, default 8, the number of ROM chips selectable (fixed 3-bit select field).
REQ-002 SHALL have port cph2  in  1  the single system clock; all state updates on posedge.
REQ-003 SHALL have port pon  in  1  asynchronous active-high reset.
REQ-004 SHALL have port sync  in  1  CTC instruction window, high T45-T54.
REQ-005 SHALL have port is  in  1  serial instruction bus, LSB first during sync.
REQ-006 SHALL have port ia  in  1  serial ROM address from CTC, LSB first T20-T27.
REQ-007 SHALL have port rom_en  out  8  one-hot selected ROM.
REQ-008 SHALL have port is_drv_en  out  8  rom_en gated to the instruction window while locked.
REQ-009 SHALL have port rom_addr  out  8  last captured ROM address.
REQ-010 SHALL have port addr_vld  out  1  one-cycle pulse when rom_addr updates.
REQ-011 SHALL have port locked  out  1  word timing aligned to sync.
REQ-012 SHALL have port sel_pend  out  1  a delayed select is armed.

Function
REQ-013 SHALL keep a 6-bit bit counter bcnt, 0..55, incrementing each cycle, wrapping 55->0.
REQ-014 SHALL treat a sync rising edge (sync=1, registered sync=0) as bit T45 and load bcnt with 46 on that edge.
REQ-015 SHALL set locked when a sync rising edge coincides with bcnt==45, clear locked when one occurs with bcnt!=45, and hold it otherwise.
REQ-016 SHALL shift is into a 10-bit register during T45-T54 (LSB first) and treat the result as the decoded instruction at T55.
REQ-017 SHALL decode an immediate select when instr[6:0]==7'b0010000, with n=instr[9:7], and register n as next_rom at T55.
REQ-018 SHALL apply next_rom to rom_en at bcnt==19 of the following word, so the next address output and fetch use the new ROM.
REQ-019 SHALL decode a delayed select when instr[6:0]==7'b0110100, with n=instr[9:7], and at T55 store n in dly_rom and set sel_pend.
REQ-020 SHALL, while sel_pend is set, on a JSB (instr[1:0]==2'b01) at T55 schedule dly_rom like an immediate select and clear sel_pend.
REQ-021 SHALL, on an immediate select while sel_pend is set, let the immediate select win and clear sel_pend.
REQ-022 SHALL let the newer delayed select replace dly_rom when a second delayed select arrives while one is pending.
REQ-023 SHALL take no selection action on instructions decoded while locked==0.
REQ-024 SHALL capture ia into rom_addr over T20-T27 and pulse addr_vld at bcnt==28 when locked.
REQ-025 SHALL drive is_drv_en = rom_en when locked and bcnt is in 45..54, and 0 otherwise.
REQ-026 SHALL keep rom_en one-hot at all times; select values at or above N_ROM are ignored.

Reset
REQ-027 SHALL, while pon is high, force bcnt=0, rom_en=8'h01, is_drv_en=0, rom_addr=0, addr_vld=0, locked=0, sel_pend=0, and clear next_rom/dly_rom and the schedule flag.
REQ-028 SHALL discard any partly shifted instruction or address on a mid-word pon assertion; after release, locked stays 0 until the first aligned sync edge that confirms it.

Structure
REQ-029 SHALL take the window boundaries (19, 20, 27, 28, 45, 54, 55) and the select opcode patterns from the shared timing package also used by the CTC.
REQ-030 SHALL implement bcnt, sync-edge detection and lock in one sub-module, word_timer; decode and selection stay in the top level.

Verification
REQ-031 SHALL cover: pon pulse, then sync every 56 cycles -> locked=1 after the 2nd aligned sync edge, rom_en=8'h01.
REQ-032 SHALL cover: instruction 10'b011_0010000 while locked -> rom_en=8'h08 exactly at T19 of the next word; is_drv_en=8'h08 during the following T45-T54.
REQ-033 SHALL cover: delayed select n=5, two non-JSB words, then a JSB -> sel_pend 1 until that JSB's T55, then rom_en=8'h20 at the following T19.
REQ-034 SHALL cover: delayed n=5 pending, then immediate select n=2 -> rom_en=8'h04, sel_pend=0, and a later JSB leaves rom_en unchanged.
REQ-035 SHALL cover: ia pattern 8'hA5 over T20-T27 -> rom_addr=8'hA5 with a single addr_vld pulse at T28.
REQ-036 SHALL cover: sync shifted by 3 cycles -> locked=0 and is_drv_en=0 for that word, relock on the next aligned edge; and pon at T50 -> all outputs at reset values, with no select applied.

Source files
------------

// File: rtl/rom_sel_ctl_pkg.sv
// Shared word-timing constants and select-opcode decode, common to the ROM select
// controller and the CTC that drives the serial buses.
package rom_sel_ctl_pkg;

  localparam int unsigned BCNT_W = 6;
  typedef logic [BCNT_W-1:0] bcnt_t;

  localparam bcnt_t T_SEL       = 6'd19;
  localparam bcnt_t T_ADDR_LO   = 6'd20;
  localparam bcnt_t T_ADDR_HI   = 6'd27;
  localparam bcnt_t T_ADDR_VLD  = 6'd28;
  localparam bcnt_t T_SYNC      = 6'd45;
  localparam bcnt_t T_INSTR_HI  = 6'd54;
  localparam bcnt_t T_DECODE    = 6'd55;
  localparam bcnt_t T_SYNC_LOAD = T_SYNC + 6'd1;

  localparam logic [6:0] OP_SEL_IMM = 7'b0010000;
  localparam logic [6:0] OP_SEL_DLY = 7'b0110100;
  localparam logic [1:0] OP_JSB     = 2'b01;

  typedef enum logic [1:0] {
    DEC_NONE,
    DEC_SEL_IMM,
    DEC_SEL_DLY,
    DEC_JSB
  } dec_e;

  typedef struct packed {
    logic [2:0] n;
    logic [6:0] op;
  } instr_t;

  // The select opcodes take priority; JSB is only recognised on the low two bits.
  function automatic dec_e decode(input instr_t i);
    if (i.op == OP_SEL_IMM)      return DEC_SEL_IMM;
    else if (i.op == OP_SEL_DLY) return DEC_SEL_DLY;
    else if (i.op[1:0] == OP_JSB) return DEC_JSB;
    else                          return DEC_NONE;
  endfunction

endpackage

// File: rtl/rom_sel_ctl_word_timer.sv
// Word bit counter (T0..T55) realigned on every sync rising edge, plus the lock
// flag that says whether that edge landed where the counter expected it.
module word_timer
  import rom_sel_ctl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       sync,
  output logic [5:0] bcnt,
  output logic [5:0] bcnt_nxt,
  output logic       locked
);

  logic  sync_q, sync_d;
  logic  locked_q, locked_d;
  bcnt_t bcnt_q, bcnt_d;
  logic  sync_rise;

  assign sync_rise = sync & ~sync_q;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sync_d   = sync;
    locked_d = locked_q;
    bcnt_d   = (bcnt_q == T_DECODE) ? '0 : bcnt_q + 6'd1;
    if (sync_rise) begin
      bcnt_d   = T_SYNC_LOAD;
      locked_d = (bcnt_q == T_SYNC);
    end
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= 1'b0;
      locked_q <= 1'b0;
      bcnt_q   <= '0;
    end else begin
      sync_q   <= sync_d;
      locked_q <= locked_d;
      bcnt_q   <= bcnt_d;
    end
  end

  assign bcnt     = bcnt_q;
  assign bcnt_nxt = bcnt_d;
  assign locked   = locked_q;

endmodule

// File: rtl/rom_sel_ctl.sv
// ROM chip select controller: decodes immediate/delayed select instructions from the
// serial instruction bus and captures the serial ROM address each word.
module rom_sel_ctl
  import rom_sel_ctl_pkg::*;
#(
  parameter int N_ROM = 8
) (
  input  logic       cph2,
  input  logic       pon,
  input  logic       sync,
  input  logic       is,
  input  logic       ia,
  output logic [7:0] rom_en,
  output logic [7:0] is_drv_en,
  output logic [7:0] rom_addr,
  output logic       addr_vld,
  output logic       locked,
  output logic       sel_pend
);

  logic [5:0] bcnt, bcnt_nxt;

  word_timer u_word_timer (
    .clk      (cph2),
    .rst      (pon),
    .sync     (sync),
    .bcnt     (bcnt),
    .bcnt_nxt (bcnt_nxt),
    .locked   (locked)
  );

  instr_t     instr_q, instr_d;
  logic [7:0] addr_sh_q, addr_sh_d;
  logic [7:0] rom_addr_q, rom_addr_d;
  logic       addr_vld_q, addr_vld_d;
  logic [7:0] rom_en_q, rom_en_d;
  logic [2:0] next_rom_q, next_rom_d;
  logic       sched_q, sched_d;
  logic [2:0] dly_rom_q, dly_rom_d;
  logic       sel_pend_q, sel_pend_d;
  logic       in_instr_win, in_addr_win;

  function automatic logic sel_ok(input logic [2:0] n);
    return int'(n) < N_ROM;
  endfunction

  assign in_instr_win = (bcnt >= T_SYNC) && (bcnt <= T_INSTR_HI);
  assign in_addr_win  = (bcnt >= T_ADDR_LO) && (bcnt <= T_ADDR_HI);

  always_comb begin
    instr_d    = instr_q;
    addr_sh_d  = addr_sh_q;
    rom_addr_d = rom_addr_q;
    addr_vld_d = 1'b0;
    rom_en_d   = rom_en_q;
    next_rom_d = next_rom_q;
    sched_d    = sched_q;
    dly_rom_d  = dly_rom_q;
    sel_pend_d = sel_pend_q;

    if (in_instr_win) instr_d = instr_t'({is, instr_q[9:1]});
    if (in_addr_win)  addr_sh_d = {ia, addr_sh_q[7:1]};

    // Last address bit arrives at T27, so the shifted value is published entering T28.
    if (locked && bcnt_nxt == T_ADDR_VLD) begin
      rom_addr_d = addr_sh_d;
      addr_vld_d = 1'b1;
    end

    if (locked && bcnt == T_DECODE) begin
      unique case (decode(instr_q))
        DEC_SEL_IMM: if (sel_ok(instr_q.n)) begin
          next_rom_d = instr_q.n;
          sched_d    = 1'b1;
          sel_pend_d = 1'b0;
        end
        DEC_SEL_DLY: if (sel_ok(instr_q.n)) begin
          dly_rom_d  = instr_q.n;
          sel_pend_d = 1'b1;
        end
        DEC_JSB: if (sel_pend_q) begin
          next_rom_d = dly_rom_q;
          sched_d    = 1'b1;
          sel_pend_d = 1'b0;
        end
        default: ;
      endcase
    end

    // Switch on entry to T19 so the whole address phase and fetch see the new ROM.
    if (sched_q && bcnt_nxt == T_SEL) begin
      rom_en_d = 8'b1 << next_rom_q;
      sched_d  = 1'b0;
    end
  end

  always_ff @(posedge cph2 or posedge pon) begin
    if (pon) begin
      instr_q    <= '0;
      addr_sh_q  <= '0;
      rom_addr_q <= '0;
      addr_vld_q <= 1'b0;
      rom_en_q   <= 8'h01;
      next_rom_q <= '0;
      sched_q    <= 1'b0;
      dly_rom_q  <= '0;
      sel_pend_q <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      addr_sh_q  <= addr_sh_d;
      rom_addr_q <= rom_addr_d;
      addr_vld_q <= addr_vld_d;
      rom_en_q   <= rom_en_d;
      next_rom_q <= next_rom_d;
      sched_q    <= sched_d;
      dly_rom_q  <= dly_rom_d;
      sel_pend_q <= sel_pend_d;
    end
  end

  assign rom_en    = rom_en_q;
  assign is_drv_en = (locked && in_instr_win) ? rom_en_q : '0;
  assign rom_addr  = rom_addr_q;
  assign addr_vld  = addr_vld_q;
  assign sel_pend  = sel_pend_q;

endmodule

// File: tb/tb_rom_sel_ctl.sv
// Directed bench for rom_sel_ctl: word-level stimulus, an integer-level reference
// model compared every cycle, and hand-computed checks at key bit times.
module tb_rom_sel_ctl;

  logic       cph2 = 1'b0;
  logic       pon, sync, is, ia;
  logic [7:0] rom_en, is_drv_en, rom_addr;
  logic       addr_vld, locked, sel_pend;

  int checks   = 0;
  int failures = 0;
  bit run_cmp  = 1'b0;

  rom_sel_ctl #(.N_ROM(8)) dut (
    .cph2      (cph2),
    .pon       (pon),
    .sync      (sync),
    .is        (is),
    .ia        (ia),
    .rom_en    (rom_en),
    .is_drv_en (is_drv_en),
    .rom_addr  (rom_addr),
    .addr_vld  (addr_vld),
    .locked    (locked),
    .sel_pend  (sel_pend)
  );

  always #5 cph2 = ~cph2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: word position, current ROM index, pending choices as
  // integers (-1 = none), instruction/address words assembled by bit weight.
  int m_t, m_nt, m_rom, m_next, m_dly, m_instr, m_acc, m_addr, m_op, m_n;
  bit m_locked, m_prev, m_vld, m_rise;

  always @(posedge cph2 or posedge pon) begin
    if (pon) begin
      m_t = 0; m_rom = 0; m_next = -1; m_dly = -1;
      m_instr = 0; m_acc = 0; m_addr = 0;
      m_locked = 1'b0; m_prev = 1'b0; m_vld = 1'b0;
    end else begin
      m_rise = sync && !m_prev;
      m_vld  = 1'b0;
      if (m_t >= 45 && m_t <= 54) begin
        if (m_t == 45) m_instr = 0;
        if (is) m_instr |= 1 << (m_t - 45);
      end
      if (m_t >= 20 && m_t <= 27) begin
        if (m_t == 20) m_acc = 0;
        if (ia) m_acc |= 1 << (m_t - 20);
      end
      if (m_t == 27 && m_locked) begin
        m_addr = m_acc;
        m_vld  = 1'b1;
      end
      if (m_t == 55 && m_locked) begin
        m_op = m_instr & 'h7f;
        m_n  = (m_instr >> 7) & 7;
        if (m_op == 'h10) begin
          m_next = m_n;
          m_dly  = -1;
        end else if (m_op == 'h34) begin
          m_dly = m_n;
        end else if (m_dly >= 0 && (m_instr & 3) == 1) begin
          m_next = m_dly;
          m_dly  = -1;
        end
      end
      m_nt = m_rise ? 46 : (m_t + 1) % 56;
      if (m_nt == 19 && m_next >= 0) begin
        m_rom  = m_next;
        m_next = -1;
      end
      if (m_rise) m_locked = (m_t == 45);
      m_t    = m_nt;
      m_prev = sync;
    end
  end

  always @(negedge cph2) begin
    if (run_cmp) begin
      check("cmp rom_en", 32'(rom_en), 32'(1 << m_rom));
      check("cmp is_drv_en", 32'(is_drv_en),
            (m_locked && m_t >= 45 && m_t <= 54) ? 32'(1 << m_rom) : 32'h0);
      check("cmp rom_addr", 32'(rom_addr), 32'(m_addr));
      check("cmp addr_vld", 32'(addr_vld), 32'(m_vld));
      check("cmp locked", 32'(locked), 32'(m_locked));
      check("cmp sel_pend", 32'(sel_pend), 32'(m_dly >= 0));
    end
  end

  // Outputs seen during each bit time of the most recent word.
  logic [7:0] obs_rom [56];
  logic [7:0] obs_drv [56];
  logic [7:0] obs_addr[56];
  logic       obs_vld [56];
  logic       obs_lock[56];
  logic       obs_pend[56];

  task automatic word(input logic [9:0] instr, input logic [7:0] addr,
                      input int sh, input int pon_at);
    logic [9:0] ish;
    logic [7:0] ash;
    ish = instr;
    ash = addr;
    for (int p = 0; p < 56; p++) begin
      @(posedge cph2);
      #1;
      obs_rom[p]  = rom_en;
      obs_drv[p]  = is_drv_en;
      obs_addr[p] = rom_addr;
      obs_vld[p]  = addr_vld;
      obs_lock[p] = locked;
      obs_pend[p] = sel_pend;
      if (pon_at >= 0 && p == pon_at)          pon = 1'b1;
      else if (pon_at >= 0 && p == pon_at + 2) pon = 1'b0;
      sync = (p >= 45 - sh) && (p <= 54 - sh);
      if (p >= 45 && p <= 54) begin
        is  = ish[0];
        ish = ish >> 1;
      end else is = 1'b0;
      if (p >= 20 && p <= 27) begin
        ia  = ash[0];
        ash = ash >> 1;
      end else ia = 1'b0;
    end
  endtask

  localparam logic [9:0] NOP  = 10'b000_0000000;
  localparam logic [9:0] JSB  = 10'b000_0000001;
  localparam logic [9:0] IMM3 = 10'b011_0010000;
  localparam logic [9:0] IMM2 = 10'b010_0010000;
  localparam logic [9:0] IMM6 = 10'b110_0010000;
  localparam logic [9:0] DLY5 = 10'b101_0110100;
  localparam logic [9:0] DLY7 = 10'b111_0110100;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pon = 1'b1; sync = 1'b0; is = 1'b0; ia = 1'b0;
    repeat (3) @(posedge cph2);
    #1;
    check("rst rom_en", 32'(rom_en), 'h01);
    check("rst is_drv_en", 32'(is_drv_en), 'h00);
    check("rst rom_addr", 32'(rom_addr), 'h00);
    check("rst addr_vld", 32'(addr_vld), 'h0);
    check("rst locked", 32'(locked), 'h0);
    check("rst sel_pend", 32'(sel_pend), 'h0);
    run_cmp = 1'b1;
    pon = 1'b0;

    // Lock acquisition: the first sync edge only realigns, the second confirms.
    word(NOP, 8'h00, 0, -1);
    check("w1 locked after 1st edge", 32'(obs_lock[50]), 'h0);
    word(NOP, 8'h00, 0, -1);
    check("w2 locked before edge", 32'(obs_lock[44]), 'h0);
    check("w2 locked after edge", 32'(obs_lock[46]), 'h1);
    check("w2 rom_en", 32'(obs_rom[50]), 'h01);

    // Immediate select n=3 plus address A5.
    word(IMM3, 8'hA5, 0, -1);
    check("w3 addr_vld@T27", 32'(obs_vld[27]), 'h0);
    check("w3 addr_vld@T28", 32'(obs_vld[28]), 'h1);
    check("w3 addr_vld@T29", 32'(obs_vld[29]), 'h0);
    check("w3 rom_addr@T28", 32'(obs_addr[28]), 'hA5);
    check("w3 is_drv_en@T50", 32'(obs_drv[50]), 'h01);
    word(NOP, 8'h00, 0, -1);
    check("w4 rom_en@T18", 32'(obs_rom[18]), 'h01);
    check("w4 rom_en@T19", 32'(obs_rom[19]), 'h08);
    check("w4 is_drv_en@T44", 32'(obs_drv[44]), 'h00);
    check("w4 is_drv_en@T45", 32'(obs_drv[45]), 'h08);
    check("w4 is_drv_en@T54", 32'(obs_drv[54]), 'h08);
    check("w4 is_drv_en@T55", 32'(obs_drv[55]), 'h00);

    // Delayed select n=5 released by a JSB two words later.
    word(DLY5, 8'h00, 0, -1);
    check("w5 sel_pend@T55", 32'(obs_pend[55]), 'h0);
    word(NOP, 8'h00, 0, -1);
    check("w6 sel_pend@T0", 32'(obs_pend[0]), 'h1);
    check("w6 rom_en@T19", 32'(obs_rom[19]), 'h08);
    word(NOP, 8'h00, 0, -1);
    check("w7 sel_pend@T30", 32'(obs_pend[30]), 'h1);
    word(JSB, 8'h00, 0, -1);
    check("w8 sel_pend@T55", 32'(obs_pend[55]), 'h1);
    word(NOP, 8'h00, 0, -1);
    check("w9 sel_pend@T0", 32'(obs_pend[0]), 'h0);
    check("w9 rom_en@T18", 32'(obs_rom[18]), 'h08);
    check("w9 rom_en@T19", 32'(obs_rom[19]), 'h20);

    // Immediate select overrides a pending delayed one.
    word(DLY5, 8'h00, 0, -1);
    word(IMM2, 8'h00, 0, -1);
    check("w11 sel_pend@T55", 32'(obs_pend[55]), 'h1);
    word(JSB, 8'h00, 0, -1);
    check("w12 sel_pend@T0", 32'(obs_pend[0]), 'h0);
    check("w12 rom_en@T19", 32'(obs_rom[19]), 'h04);
    word(NOP, 8'h00, 0, -1);
    check("w13 rom_en@T19", 32'(obs_rom[19]), 'h04);
    check("w13 rom_en@T55", 32'(obs_rom[55]), 'h04);
    check("w13 sel_pend@T55", 32'(obs_pend[55]), 'h0);

    // pon at T50 while a delayed select is pending and an immediate one is shifting.
    word(DLY7, 8'h00, 0, -1);
    word(IMM6, 8'h5A, 0, 50);
    check("w15 sel_pend@T49", 32'(obs_pend[49]), 'h1);
    check("w15 rom_addr@T49", 32'(obs_addr[49]), 'h5A);
    check("w15 rom_en@T51", 32'(obs_rom[51]), 'h01);
    check("w15 is_drv_en@T51", 32'(obs_drv[51]), 'h00);
    check("w15 rom_addr@T51", 32'(obs_addr[51]), 'h00);
    check("w15 locked@T51", 32'(obs_lock[51]), 'h0);
    check("w15 sel_pend@T51", 32'(obs_pend[51]), 'h0);
    word(NOP, 8'h00, 0, -1);
    check("w16 locked@T50", 32'(obs_lock[50]), 'h0);
    check("w16 rom_en@T19", 32'(obs_rom[19]), 'h01);
    check("w16 rom_en@T55", 32'(obs_rom[55]), 'h01);
    word(NOP, 8'h00, 0, -1);
    check("w17 locked@T46", 32'(obs_lock[46]), 'h1);
    check("w17 is_drv_en@T50", 32'(obs_drv[50]), 'h01);

    // Sync arrives 3 bit times early: lock drops, then the next word relocks.
    word(NOP, 8'h00, 3, -1);
    check("w18 locked before shifted edge", 32'(obs_lock[42]), 'h1);
    check("w18 locked after shifted edge", 32'(obs_lock[43]), 'h0);
    check("w18 is_drv_en@47", 32'(obs_drv[47]), 'h00);
    check("w18 is_drv_en@50", 32'(obs_drv[50]), 'h00);
    word(NOP, 8'h00, 3, -1);
    check("w19 locked before edge", 32'(obs_lock[42]), 'h0);
    check("w19 relocked", 32'(obs_lock[43]), 'h1);
    check("w19 is_drv_en@44", 32'(obs_drv[44]), 'h01);

    run_cmp = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
